// File: rtl/button_event_ctrl_pkg.sv
// Shared definitions for the button event controller: FSM encoding and
// counter width helpers.
package button_event_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PRESS     = 2'd1,
      ST_HOLD_LONG = 2'd2,
      ST_CFG_WAIT  = 2'd3
   } state_t;

   // Smallest r with 2**r >= v (v >= 1).
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((longint'(1) << i) < longint'(v)) r = i + 1;
      end
      return r;
   endfunction

   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      if (m < 2) m = 2;
      return clog2(m);
   endfunction

endpackage

// File: rtl/button_event_ctrl_rise_edge.sv
// Registered rising-edge detector for an already clean, synchronous level.
// The reset value of the history register is selectable.
module rise_edge #(
   parameter bit RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic rise
);

   logic q;

   always_ff @(posedge clk) begin
      if (!rstn) q <= RST_VAL;
      else       q <= d;
   end

   assign rise = d & ~q;

endmodule

// File: rtl/button_event_ctrl.sv
// Classifies debounced button presses as short (config start request with
// done/timeout tracking) or long (soft-reset request).
module button_event_ctrl
   import button_event_ctrl_pkg::*;
#(
   parameter int LONG_PRESS  = 100_000_000,
   parameter int CFG_TIMEOUT = 10_000_000
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_btn,
   input  logic       i_cfg_done,
   output logic       o_cfg_start,
   output logic       o_soft_rst,
   output logic       o_busy,
   output logic       o_cfg_err,
   output logic [1:0] o_state
);

   localparam int              CNT_W     = cnt_width(LONG_PRESS, CFG_TIMEOUT);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = (CFG_TIMEOUT == 0) ? '0 : CNT_W'(CFG_TIMEOUT - 1);
   localparam bit              TMO_EN    = (CFG_TIMEOUT != 0);

   state_t             state;
   logic [CNT_W-1:0]   hold_cnt;
   logic [CNT_W-1:0]   tmo_cnt;
   logic               rise;

   // History resets to 1 so a button held through reset needs a release first.
   rise_edge #(.RST_VAL(1'b1)) u_rise (
      .clk  (i_clk),
      .rstn (i_rstn),
      .d    (i_btn),
      .rise (rise)
   );

   // Config handshake: o_cfg_start is a one-cycle request; o_busy stays high
   // until i_cfg_done is seen (pulse or level, any cycle from the request on)
   // or the timeout expires, whichever comes first; done wins a tie.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state       <= ST_IDLE;
         hold_cnt    <= '0;
         tmo_cnt     <= '0;
         o_cfg_start <= 1'b0;
         o_soft_rst  <= 1'b0;
         o_cfg_err   <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         o_cfg_start <= 1'b0;
         o_soft_rst  <= 1'b0;
         o_cfg_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rise) begin
                  state    <= ST_PRESS;
                  hold_cnt <= '0;
               end
            end
            ST_PRESS: begin
               // Release is checked first so it beats the terminal count.
               if (!i_btn) begin
                  state       <= ST_CFG_WAIT;
                  tmo_cnt     <= '0;
                  o_cfg_start <= 1'b1;
                  o_busy      <= 1'b1;
               end else if (hold_cnt == HOLD_LAST) begin
                  state      <= ST_HOLD_LONG;
                  o_soft_rst <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            ST_HOLD_LONG: begin
               if (!i_btn) state <= ST_IDLE;
            end
            ST_CFG_WAIT: begin
               if (i_cfg_done) begin
                  state  <= ST_IDLE;
                  o_busy <= 1'b0;
               end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                  state     <= ST_IDLE;
                  o_cfg_err <= 1'b1;
                  o_busy    <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with LONG_PRESS=16, CFG_TIMEOUT=32;
// output pulses are matched against a queue of expected {event, cycle} words.
module tb_button_event_ctrl;

   localparam int LP  = 16;
   localparam int TMO = 32;

   localparam logic [3:0] EV_START = 4'd1;
   localparam logic [3:0] EV_SRST  = 4'd2;
   localparam logic [3:0] EV_ERR   = 4'd3;
   localparam logic [3:0] EV_BFALL = 4'd4;

   logic       i_clk      = 1'b0;
   logic       i_rstn     = 1'b0;
   logic       i_btn      = 1'b0;
   logic       i_cfg_done = 1'b0;
   logic       o_cfg_start;
   logic       o_soft_rst;
   logic       o_busy;
   logic       o_cfg_err;
   logic [1:0] o_state;

   int          cyc    = 0;
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   logic        busy_prev = 1'b0;
   int          e, s;

   button_event_ctrl #(.LONG_PRESS(LP), .CFG_TIMEOUT(TMO)) dut (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_btn       (i_btn),
      .i_cfg_done  (i_cfg_done),
      .o_cfg_start (o_cfg_start),
      .o_soft_rst  (o_soft_rst),
      .o_busy      (o_busy),
      .o_cfg_err   (o_cfg_err),
      .o_state     (o_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   function automatic logic [31:0] ev(input logic [3:0] k, input int c);
      logic [31:0] cc;
      cc = c;
      return {k, cc[27:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic sb_check(input logic [3:0] kind);
      logic [31:0] got, want;
      got = ev(kind, cyc);
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            n_fail++;
            $display("FAIL event: got kind %0d cycle %0d, expected kind %0d cycle %0d",
                     got[31:28], got[27:0], want[31:28], want[27:0]);
         end
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) tick();
   endtask

   // ---------------- monitor ----------------
   always @(negedge i_clk) begin
      if (i_rstn) begin
         if (o_cfg_start) sb_check(EV_START);
         if (o_soft_rst)  sb_check(EV_SRST);
         if (o_cfg_err)   sb_check(EV_ERR);
         if (busy_prev && !o_busy) sb_check(EV_BFALL);
      end
      busy_prev = o_busy;
   end

   // ---------------- driver ----------------
   initial begin
      // Reset state
      wait_cyc(3);
      @(negedge i_clk);
      check("rst_start", 32'(o_cfg_start), 32'd0);
      check("rst_srst",  32'(o_soft_rst),  32'd0);
      check("rst_err",   32'(o_cfg_err),   32'd0);
      check("rst_busy",  32'(o_busy),      32'd0);
      check("rst_state", 32'(o_state),     32'd0);
      wait_cyc(4);
      i_rstn = 1'b1;
      wait_cyc(8);

      // Short press: 5 high cycles, done 10 cycles after the start pulse
      e = cyc;
      i_btn = 1'b1;
      wait_cyc(e + 5);
      i_btn = 1'b0;
      exp_q.push_back(ev(EV_START, e + 6));
      wait_cyc(e + 10);
      @(negedge i_clk);
      check("short_state_wait", 32'(o_state), 32'd3);
      check("short_busy",       32'(o_busy),  32'd1);
      wait_cyc(e + 16);
      i_cfg_done = 1'b1;
      exp_q.push_back(ev(EV_BFALL, e + 17));
      wait_cyc(e + 17);
      i_cfg_done = 1'b0;
      @(negedge i_clk);
      check("short_state_idle", 32'(o_state), 32'd0);
      wait_cyc(e + 20);

      // Long press: held 40 cycles, soft reset at E+17 only
      e = cyc;
      i_btn = 1'b1;
      exp_q.push_back(ev(EV_SRST, e + LP + 1));
      wait_cyc(e + 10);
      @(negedge i_clk);
      check("long_state_press", 32'(o_state), 32'd1);
      wait_cyc(e + 30);
      @(negedge i_clk);
      check("long_state_hold", 32'(o_state), 32'd2);
      wait_cyc(e + 40);
      i_btn = 1'b0;
      wait_cyc(e + 41);
      @(negedge i_clk);
      check("long_state_idle", 32'(o_state), 32'd0);
      wait_cyc(e + 44);

      // Timeout: no done, error 32 cycles after start
      e = cyc;
      i_btn = 1'b1;
      wait_cyc(e + 3);
      i_btn = 1'b0;
      s = e + 4;
      exp_q.push_back(ev(EV_START, s));
      exp_q.push_back(ev(EV_ERR, s + TMO));
      exp_q.push_back(ev(EV_BFALL, s + TMO));
      wait_cyc(s + TMO - 1);
      @(negedge i_clk);
      check("tmo_state_last", 32'(o_state), 32'd3);
      check("tmo_busy_last",  32'(o_busy),  32'd1);
      wait_cyc(s + TMO + 3);
      @(negedge i_clk);
      check("tmo_state_idle", 32'(o_state), 32'd0);

      // Done coinciding with the terminal timeout count: done wins
      e = cyc;
      i_btn = 1'b1;
      wait_cyc(e + 3);
      i_btn = 1'b0;
      s = e + 4;
      exp_q.push_back(ev(EV_START, s));
      wait_cyc(s + TMO - 1);
      i_cfg_done = 1'b1;
      exp_q.push_back(ev(EV_BFALL, s + TMO));
      wait_cyc(s + TMO);
      i_cfg_done = 1'b0;
      wait_cyc(s + TMO + 1);
      @(negedge i_clk);
      check("coin_state_idle", 32'(o_state), 32'd0);
      wait_cyc(s + TMO + 4);

      // Done during the start cycle: busy for one cycle only
      e = cyc;
      i_btn = 1'b1;
      wait_cyc(e + 2);
      i_btn = 1'b0;
      s = e + 3;
      wait_cyc(s);
      i_cfg_done = 1'b1;
      exp_q.push_back(ev(EV_START, s));
      exp_q.push_back(ev(EV_BFALL, s + 1));
      wait_cyc(s + 1);
      i_cfg_done = 1'b0;
      @(negedge i_clk);
      check("fast_busy_low", 32'(o_busy),  32'd0);
      check("fast_state",    32'(o_state), 32'd0);
      wait_cyc(s + 4);

      // Reset mid-press at hold_cnt = 8, button kept held through and after
      e = cyc;
      i_btn = 1'b1;
      wait_cyc(e + 9);
      i_rstn = 1'b0;
      wait_cyc(e + 10);
      @(negedge i_clk);
      check("mid_rst_state", 32'(o_state),    32'd0);
      check("mid_rst_start", 32'(o_cfg_start), 32'd0);
      check("mid_rst_srst",  32'(o_soft_rst),  32'd0);
      check("mid_rst_busy",  32'(o_busy),      32'd0);
      i_rstn = 1'b1;
      wait_cyc(e + 30);
      @(negedge i_clk);
      check("held_no_press", 32'(o_state), 32'd0);
      wait_cyc(e + 40);
      i_btn = 1'b0;
      wait_cyc(e + 43);
      e = cyc;
      i_btn = 1'b1;
      wait_cyc(e + 2);
      i_btn = 1'b0;
      exp_q.push_back(ev(EV_START, e + 3));
      wait_cyc(e + 6);
      i_cfg_done = 1'b1;
      exp_q.push_back(ev(EV_BFALL, e + 7));
      wait_cyc(e + 7);
      i_cfg_done = 1'b0;
      wait_cyc(e + 10);

      // Busy lockout: press during CFG_WAIT is ignored
      e = cyc;
      i_btn = 1'b1;
      wait_cyc(e + 3);
      i_btn = 1'b0;
      s = e + 4;
      exp_q.push_back(ev(EV_START, s));
      wait_cyc(s + 3);
      i_btn = 1'b1;
      wait_cyc(s + 6);
      i_btn = 1'b0;
      wait_cyc(s + 10);
      i_cfg_done = 1'b1;
      exp_q.push_back(ev(EV_BFALL, s + 11));
      wait_cyc(s + 11);
      i_cfg_done = 1'b0;
      wait_cyc(s + 12);
      @(negedge i_clk);
      check("lockout_state", 32'(o_state), 32'd0);
      e = cyc + 1;
      wait_cyc(e);
      i_btn = 1'b1;
      wait_cyc(e + 2);
      i_btn = 1'b0;
      exp_q.push_back(ev(EV_START, e + 3));
      wait_cyc(e + 8);
      i_cfg_done = 1'b1;
      exp_q.push_back(ev(EV_BFALL, e + 9));
      wait_cyc(e + 9);
      i_cfg_done = 1'b0;
      wait_cyc(e + 14);

      // Every expected event must have been observed
      @(negedge i_clk);
      check("sb_leftover", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
